// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory arbiter.
//   arb_state_t : arbiter FSM states
//   owner_t     : which cache last owned the memory (for round-robin on contention)
//   BLOCK_OFF_W : number of byte-offset bits inside one cache block
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        I_FILL,
        D_FILL,
        D_WRITE
    } arb_state_t;

    typedef enum logic {
        OWN_I,
        OWN_D
    } owner_t;

    // Block byte-offset width: word index bits plus one bit for the byte within a 2-byte word.
    function automatic int unsigned BLOCK_OFF_W(input int unsigned block_words);
        return $clog2(block_words) + 1;
    endfunction

endpackage

// File: rtl/mem_arb_burst_ctr.sv
// Saturating burst word counter.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear (priority over inc)
//   inc      : advance by one unless already at the last word
//   count    : current word index
//   last     : count is at the final word of the block
module mem_arb_burst_ctr #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count,
    output logic             last
);

    always_comb begin
        last = (count == '1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !last) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single pipelined main memory between the I-cache and D-cache
// fill FSMs, and serves single-word D-cache write-through stores.
//   clk, rst        : clock, asynchronous active-high reset
//   icache_req/addr : I-cache block fill request (level, held until icache_done)
//   icache_grant/valid/done : I-cache owns memory / word returned / last word returned
//   dcache_req/we/addr/wdata: D-cache fill (we=0) or single-word write (we=1) request
//   dcache_grant/valid/done : D-cache owns memory / word returned / fill done or write accepted
//   mem_enable/wr/addr/wdata: memory access strobe, write select, byte address, write data
//   mem_data_valid  : read data return from the fixed-latency memory pipeline
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned BLOCK_WORDS = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              icache_req,
    input  logic [ADDR_W-1:0] icache_addr,
    output logic              icache_grant,
    output logic              icache_valid,
    output logic              icache_done,
    input  logic              dcache_req,
    input  logic              dcache_we,
    input  logic [ADDR_W-1:0] dcache_addr,
    input  logic [DATA_W-1:0] dcache_wdata,
    output logic              dcache_grant,
    output logic              dcache_valid,
    output logic              dcache_done,
    output logic              mem_enable,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_data_valid
);

    localparam int unsigned CNT_W = $clog2(BLOCK_WORDS);
    localparam int unsigned OFF_W = BLOCK_OFF_W(BLOCK_WORDS);
    localparam logic [ADDR_W-1:0] OFF_MASK  = ADDR_W'((1 << OFF_W) - 1);
    localparam logic [ADDR_W-1:0] BYTE_MASK = ADDR_W'(1);

    arb_state_t        state, next_state;
    owner_t            last_owner;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              pick_d;
    logic              fill;
    logic              issue_done;
    logic              issue_en;
    logic              issue_last;
    logic              recv_inc;
    logic              recv_last;
    logic              fill_done;
    logic              ctr_clr;
    logic [CNT_W-1:0]  issue_cnt;
    logic [CNT_W-1:0]  recv_cnt;

    // Burst bookkeeping: issue runs ahead of receive; both clear whenever no fill is active.
    always_comb begin
        fill      = (state == I_FILL) || (state == D_FILL);
        issue_en  = fill && !issue_done;
        recv_inc  = fill && mem_data_valid;
        fill_done = recv_inc && recv_last;
        ctr_clr   = !fill || fill_done;
    end

    mem_arb_burst_ctr #(.WIDTH(CNT_W)) u_issue_ctr (
        .clk   (clk),
        .rst   (rst),
        .clr   (ctr_clr),
        .inc   (issue_en),
        .count (issue_cnt),
        .last  (issue_last)
    );

    mem_arb_burst_ctr #(.WIDTH(CNT_W)) u_recv_ctr (
        .clk   (clk),
        .rst   (rst),
        .clr   (ctr_clr),
        .inc   (recv_inc),
        .count (recv_cnt),
        .last  (recv_last)
    );

    // Next state and arbitration decision. On contention the requester that did
    // not own memory last time wins, so neither cache can starve.
    always_comb begin
        next_state = state;
        pick_d     = 1'b0;
        case (state)
            IDLE: begin
                if (icache_req && dcache_req) begin
                    pick_d = (last_owner == OWN_I);
                end else begin
                    pick_d = dcache_req;
                end
                if (icache_req || dcache_req) begin
                    if (pick_d) begin
                        next_state = dcache_we ? D_WRITE : D_FILL;
                    end else begin
                        next_state = I_FILL;
                    end
                end
            end
            I_FILL, D_FILL: begin
                if (fill_done) begin
                    next_state = IDLE;
                end
            end
            D_WRITE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_owner <= OWN_I;
            addr_q     <= '0;
            wdata_q    <= '0;
            issue_done <= 1'b0;
        end else begin
            state <= next_state;
            if ((state == IDLE) && (next_state != IDLE)) begin
                last_owner <= pick_d ? OWN_D : OWN_I;
                wdata_q    <= dcache_wdata;
                if (!pick_d) begin
                    addr_q <= icache_addr & ~OFF_MASK;
                end else if (dcache_we) begin
                    addr_q <= dcache_addr & ~BYTE_MASK;
                end else begin
                    addr_q <= dcache_addr & ~OFF_MASK;
                end
            end
            // The issue counter saturates on the last word, so a flag marks the burst as fully issued.
            if (ctr_clr) begin
                issue_done <= 1'b0;
            end else if (issue_en && issue_last) begin
                issue_done <= 1'b1;
            end
        end
    end

    always_comb begin
        icache_grant = (state == I_FILL);
        dcache_grant = (state == D_FILL) || (state == D_WRITE);
        icache_valid = recv_inc && (state == I_FILL);
        dcache_valid = recv_inc && (state == D_FILL);
        icache_done  = fill_done && (state == I_FILL);
        dcache_done  = (fill_done && (state == D_FILL)) || (state == D_WRITE);
        mem_enable   = 1'b0;
        mem_wr       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        if (issue_en) begin
            mem_enable = 1'b1;
            mem_addr   = {addr_q[ADDR_W-1:OFF_W], issue_cnt, 1'b0};
        end else if (state == D_WRITE) begin
            mem_enable = 1'b1;
            mem_wr     = 1'b1;
            mem_addr   = addr_q;
            mem_wdata  = wdata_q;
        end
    end

endmodule
